// File: rtl/matrix_scan_ctrl.sv
// ---------------------------------------------------------------------------
// matrix_scan_ctrl
//
// Consumer of the tactile scan pulse generator. Converts the end-of-row
// pulse (pulse_sw) and the cell-slot pulse (pulse_rd) into registered
// switch/read wire selects. Runs one ADC conversion per accepted cell slot
// after a settle delay and emits each sample as a tagged pixel on a
// valid/ready stream. Also flags row misalignment (sticky sync_err) and
// counts slots dropped because the previous pixel was still in flight.
//
// Optional feature macro: SCAN_DROP_CNT_EN
//   defined   : 16-bit saturating drop counter drives drop_cnt
//   undefined : counter removed, drop_cnt tied to 0 (drop behaviour itself
//               is unchanged)
//
// Ports
//   clk_ref            in   single clock
//   rst_n              in   asynchronous active-low reset
//   active_on          in   scan enable
//   pulse_sw           in   end-of-row marker, one cycle
//   pulse_rd           in   cell-slot start, one cycle
//   sw_sel  [ROW_W]    out  active row index
//   sw_en              out  row driver enable (active_on delayed one cycle)
//   rd_sel  [COL_W]    out  active column index
//   adc_start          out  conversion request, one cycle
//   adc_done           in   conversion complete, one cycle
//   adc_data [ADC_W]   in   sample, valid with adc_done
//   px_valid / px_ready     pixel handshake
//   px_data [ADC_W]    out  pixel sample
//   px_row  [ROW_W]    out  pixel row tag
//   px_col  [COL_W]    out  pixel column tag
//   px_sof / px_eof    out  pixel is (0,0) / (SW-1,RD-1), qualified by px_valid
//   sync_err           out  sticky row misalignment flag
//   drop_cnt [16]      out  dropped-slot count
//   dbg_state [3]      out  current FSM state (state_t encoding)
//
// Handshake: a pixel transfers on a rising clk_ref edge where px_valid and
// px_ready are both high. Once raised, px_valid and the whole payload hold
// stable until that edge; px_valid is low the cycle after, so at most one
// pixel is ever in flight.
//
// Timing: pulse inputs and active_on are registered first. A pulse_rd
// sampled at edge N is acted on at edge N+1 (selects update there), and
// adc_start is high in the cycle following edge N+1+SETTLE.
// ---------------------------------------------------------------------------
module matrix_scan_ctrl #(
  parameter int SW_WIRE_CNT = 16,
  parameter int RD_WIRE_CNT = 16,
  parameter int ADC_W       = 12,
  parameter int SETTLE      = 2,
  localparam int ROW_W = (SW_WIRE_CNT > 1) ? $clog2(SW_WIRE_CNT) : 1,
  localparam int COL_W = (RD_WIRE_CNT > 1) ? $clog2(RD_WIRE_CNT) : 1
) (
  input  logic             clk_ref,
  input  logic             rst_n,
  input  logic             active_on,
  input  logic             pulse_sw,
  input  logic             pulse_rd,
  output logic [ROW_W-1:0] sw_sel,
  output logic             sw_en,
  output logic [COL_W-1:0] rd_sel,
  output logic             adc_start,
  input  logic             adc_done,
  input  logic [ADC_W-1:0] adc_data,
  output logic             px_valid,
  input  logic             px_ready,
  output logic [ADC_W-1:0] px_data,
  output logic [ROW_W-1:0] px_row,
  output logic [COL_W-1:0] px_col,
  output logic             px_sof,
  output logic             px_eof,
  output logic             sync_err,
  output logic [15:0]      drop_cnt,
  output logic [2:0]       dbg_state
);

  localparam int CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(SW_WIRE_CNT - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(RD_WIRE_CNT - 1);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_LAST);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_CONV   = 3'd2,
    S_WAIT   = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t             state_q, state_d;

  // Registered copies of the scan-side inputs.
  logic               active_q;
  logic               pulse_rd_q;
  logic               pulse_sw_q;

  // Next-cell pointer.
  logic [ROW_W-1:0]   nrow_q, nrow_d;
  logic [COL_W-1:0]   ncol_q, ncol_d;

  logic [ROW_W-1:0]   sw_sel_q, sw_sel_d;
  logic [COL_W-1:0]   rd_sel_q, rd_sel_d;
  logic [ROW_W-1:0]   px_row_q, px_row_d;
  logic [COL_W-1:0]   px_col_q, px_col_d;
  logic [ADC_W-1:0]   px_data_q, px_data_d;
  logic               px_valid_q, px_valid_d;
  logic               px_sof_q, px_sof_d;
  logic               px_eof_q, px_eof_d;
  logic               adc_start_q, adc_start_d;
  logic               sync_err_q, sync_err_d;
  logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;

  // Qualified scan events; everything is ignored while the scan is disabled.
  logic               rd_ev;
  logic               sw_ev;
  logic               in_idle;
  logic               accept;
  logic               col_last;
  logic [ROW_W-1:0]   row_inc;

  assign rd_ev    = active_q & pulse_rd_q;
  assign sw_ev    = active_q & pulse_sw_q;
  assign in_idle  = (state_q == S_IDLE);
  assign accept   = rd_ev & in_idle;
  assign col_last = (ncol_q == COL_LAST);
  assign row_inc  = (nrow_q == ROW_LAST) ? '0 : nrow_q + ROW_W'(1);

  // -------------------------------------------------------------------------
  // Pointer and misalignment tracking
  // -------------------------------------------------------------------------
  always_comb begin
    nrow_d     = nrow_q;
    ncol_d     = ncol_q;
    sync_err_d = sync_err_q;

    if (in_idle && !active_q) begin
      // Disabled and idle: the next enabled scan restarts at (0,0).
      nrow_d = '0;
      ncol_d = '0;
    end else if (sw_ev) begin
      // End-of-row overrides the normal advance. It must land on the last
      // column's slot; anything else means the generator and we disagree.
      nrow_d = row_inc;
      ncol_d = '0;
      if (!rd_ev || !col_last) begin
        sync_err_d = 1'b1;
      end
    end else if (rd_ev) begin
      // Accepted and dropped slots advance the pointer alike.
      if (col_last) begin
        ncol_d = '0;
        nrow_d = row_inc;
      end else begin
        ncol_d = ncol_q + COL_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Measurement FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    sw_sel_d     = sw_sel_q;
    rd_sel_d     = rd_sel_q;
    px_row_d     = px_row_q;
    px_col_d     = px_col_q;
    px_data_d    = px_data_q;
    px_valid_d   = px_valid_q;
    px_sof_d     = px_sof_q;
    px_eof_d     = px_eof_q;
    settle_cnt_d = settle_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          sw_sel_d     = nrow_q;
          rd_sel_d     = ncol_q;
          px_row_d     = nrow_q;
          px_col_d     = ncol_q;
          settle_cnt_d = '0;
          state_d      = (SETTLE == 0) ? S_CONV : S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (settle_cnt_q == SETTLE_END) begin
          state_d = S_CONV;
        end else begin
          settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end
      end

      S_CONV: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (adc_done) begin
          px_data_d  = adc_data;
          px_valid_d = 1'b1;
          px_sof_d   = (px_row_q == '0) && (px_col_q == '0);
          px_eof_d   = (px_row_q == ROW_LAST) && (px_col_q == COL_LAST);
          state_d    = S_OUT;
        end
      end

      S_OUT: begin
        if (px_ready) begin
          px_valid_d = 1'b0;
          px_sof_d   = 1'b0;
          px_eof_d   = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // adc_start is high for exactly the one cycle the FSM spends in CONV.
  assign adc_start_d = (state_d == S_CONV);

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      active_q     <= 1'b0;
      pulse_rd_q   <= 1'b0;
      pulse_sw_q   <= 1'b0;
      nrow_q       <= '0;
      ncol_q       <= '0;
      sw_sel_q     <= '0;
      rd_sel_q     <= '0;
      px_row_q     <= '0;
      px_col_q     <= '0;
      px_data_q    <= '0;
      px_valid_q   <= 1'b0;
      px_sof_q     <= 1'b0;
      px_eof_q     <= 1'b0;
      adc_start_q  <= 1'b0;
      sync_err_q   <= 1'b0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_on;
      pulse_rd_q   <= pulse_rd;
      pulse_sw_q   <= pulse_sw;
      nrow_q       <= nrow_d;
      ncol_q       <= ncol_d;
      sw_sel_q     <= sw_sel_d;
      rd_sel_q     <= rd_sel_d;
      px_row_q     <= px_row_d;
      px_col_q     <= px_col_d;
      px_data_q    <= px_data_d;
      px_valid_q   <= px_valid_d;
      px_sof_q     <= px_sof_d;
      px_eof_q     <= px_eof_d;
      adc_start_q  <= adc_start_d;
      sync_err_q   <= sync_err_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Dropped-slot counter
  // -------------------------------------------------------------------------
`ifdef SCAN_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // A slot arriving while a pixel is still in flight (including the cycle
  // the OUT handshake completes) cannot be measured.
  assign drop = rd_ev & ~in_idle;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  assign sw_sel    = sw_sel_q;
  assign sw_en     = active_q;
  assign rd_sel    = rd_sel_q;
  assign adc_start = adc_start_q;
  assign px_valid  = px_valid_q;
  assign px_data   = px_data_q;
  assign px_row    = px_row_q;
  assign px_col    = px_col_q;
  assign px_sof    = px_sof_q;
  assign px_eof    = px_eof_q;
  assign sync_err  = sync_err_q;
  assign dbg_state = state_q;

endmodule

// File: doc/matrix_scan_ctrl.md
# matrix_scan_ctrl

Downstream consumer of the tactile scan pulse generator. It turns `pulse_sw` (end-of-row) and `pulse_rd` (cell slot) into registered switch/read wire selects, runs one ADC conversion per cell slot with a settle delay, and emits each sample as a tagged pixel on a valid/ready stream. It also flags row misalignment and dropped slots.

## Interface
- `SW_WIRE_CNT`, default 16: number of switch wires (rows).
- `RD_WIRE_CNT`, default 16: number of read wires (columns).
- `ADC_W`, default 12: ADC sample width.
- `SETTLE`, default 2: cycles between select update and `adc_start`. 0 is legal.
- Local widths: `ROW_W = max(1, $clog2(SW_WIRE_CNT))` and `COL_W = max(1, $clog2(RD_WIRE_CNT))`.

Ports:
- `clk_ref` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `active_on` in 1: scan enable.
- `pulse_sw` in 1: end-of-row marker, one cycle wide.
- `pulse_rd` in 1: cell-slot start, one cycle wide.
- `sw_sel` out ROW_W: active row index.
- `sw_en` out 1: row driver enable, equal to registered `active_on`.
- `rd_sel` out COL_W: active column index.
- `adc_start` out 1: conversion request, one cycle wide.
- `adc_done` in 1: conversion complete, one cycle wide.
- `adc_data` in ADC_W: sample, valid when `adc_done` is high.
- `px_valid` out 1, `px_ready` in 1: pixel handshake.
- `px_data` out ADC_W, `px_row` out ROW_W, `px_col` out COL_W: pixel payload.
- `px_sof` out 1: pixel is (0,0). `px_eof` out 1: pixel is (SW-1, RD-1).
- `sync_err` out 1: sticky misalignment flag.
- `drop_cnt` out 16: dropped-slot count.

## Operation
- Next-cell pointer (`nrow`, `ncol`) resets to (0,0).
- FSM states are IDLE, SETTLE, CONV, WAIT, OUT.
- **IDLE**, on `pulse_rd` with `active_on` high:
  - Latch `sw_sel<=nrow` and `rd_sel<=ncol`. Latch the payload tags to the same values.
  - Go to SETTLE, or to CONV if SETTLE=0.
- **Pointer advance** on every accepted `pulse_rd`, and on every dropped one:
  - `ncol` increments and wraps at RD-1.
  - When `ncol` wraps, `nrow` increments and wraps at SW-1.
- **`pulse_sw`** forces the next pointer to (`nrow`+1 wrapping, 0). This has priority over the normal advance.
  - `pulse_sw` is expected coincident with a `pulse_rd` whose slot has `ncol`=RD-1.
  - `pulse_sw` with `ncol`≠RD-1, or without `pulse_rd`, sets `sync_err`.
  - `sync_err` clears only on reset.
- **SETTLE**: count SETTLE cycles, then go to CONV.
- **CONV**: assert `adc_start` for one cycle, then go to WAIT.
- **WAIT**: on `adc_done`, capture `adc_data` into `px_data` and go to OUT.
- **OUT**: hold `px_valid` and the payload stable until `px_ready`. Then go to IDLE.
- **Drops**: a `pulse_rd` arriving in any state other than IDLE is a drop. This includes the cycle in which the OUT handshake completes.
  - The pointer still advances on a drop.
  - `drop_cnt` increments, saturating at 0xFFFF.
- **`active_on` low**:
  - New pulses are ignored and do not advance the pointer.
  - An in-flight pixel completes normally.
  - While in IDLE with `active_on` low, the pointer resets to (0,0).

## Timing
- Every output is 0 at reset, including `sync_err`, `drop_cnt` and the selects.
- `pulse_rd` sampled at edge N:
  - `sw_sel`/`rd_sel` are valid after edge N+1.
  - `adc_start` is high during cycle N+1+SETTLE.
- `adc_done` is sampled only in WAIT, so it may arrive no earlier than one cycle after `adc_start`.
- `px_valid` rises the cycle after `adc_done` is sampled.
- The handshake completes on an edge with `px_valid`&&`px_ready`. `px_valid` is low the following cycle, so there is at most one pixel in flight.
- `px_sof` and `px_eof` are qualified by `px_valid`.
- `sw_en` lags `active_on` by one cycle.
- Asserting `rst_n` low mid-conversion:
  - All outputs clear immediately.
  - The FSM returns to IDLE.
  - A late `adc_done` after release is ignored.
- Simultaneous `pulse_rd` and `pulse_sw` in IDLE: the slot measures the current pointer, and the next pointer is (`nrow`+1, 0).

## Configuration
- `SCAN_DROP_CNT_EN`:
  - Defined: the 16-bit saturating drop counter is built as described.
  - Undefined: the counter logic is removed and `drop_cnt` is tied to 0. Drop behaviour is otherwise unchanged: the slot is still dropped and the pointer still advances.

## Test plan
- **Full frame.** SW=4, RD=4, SETTLE=2, `px_ready`=1, ADC answers 3 cycles after `adc_start` with data=row*16+col, `pulse_rd` every 20 cycles and `pulse_sw` on every 4th.
  - 16 pixels in raster order (0,0)…(3,3) with matching data.
  - `px_sof` only on (0,0), `px_eof` only on (3,3).
  - `sync_err`=0. After the frame wraps, the next pixel is (0,0).
- **Settle/start timing.** `pulse_rd` at edge 10, SETTLE=2.
  - Selects change after edge 11.
  - `adc_start` is high in exactly one cycle, cycle 13.
- **Backpressure.** Hold `px_ready`=0 for 30 cycles and issue a `pulse_rd` during OUT.
  - Payload is stable throughout.
  - `drop_cnt`=1 and the pointer skips that cell.
  - The next accepted pixel has `col`+2.
- **Misalignment.** `pulse_sw` at `ncol`=1.
  - `sync_err`=1 and stays 1.
  - The next pixel is (row+1, 0).
- **Reset mid-WAIT.** Drive `rst_n` low for 2 cycles, then `adc_done` after release.
  - All outputs are 0.
  - No pixel is emitted.
  - The next `pulse_rd` measures (0,0).
- **Macro off.** Without `SCAN_DROP_CNT_EN`, repeat the backpressure scenario.
  - `drop_cnt` stays 0.
  - The pixel sequence is identical to the macro-on run.
